hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline control that drives the enable and bubble inputs of the PC, IF/ID,
//  ID/EX and EX/MEM registers. It is the producer of the en_reg and rst
//  (bubble) strobes those registers consume.
//  Detects load-use hazards and taken-branch flushes. Freezes the front end
//  for a fixed latency while a multi-cycle multiply or divide occupies EX.
// PARAMETERS
//  MUL_LAT  4   total frozen cycles for a multiply (>=1)
//  DIV_LAT  32  total frozen cycles for a divide (>=1)
//  CNT_W    6   busy-counter width; must hold max(MUL_LAT,DIV_LAT)-1
//  PERF_W   32  width of performance counters (HAZ_PERF_EN only)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  id_rs         in   5      rs field of instruction in ID
//  id_rt         in   5      rt field of instruction in ID
//  id_uses_rt    in   1      ID instruction reads rt
//  ex_rt         in   5      destination rt of instruction in EX
//  ex_mem_read   in   1      EX instruction is a load
//  ex_mdu_start  in   1      EX instruction is mult/div, first EX cycle
//  ex_mdu_div    in   1      qualifies ex_mdu_start: 1=divide, 0=multiply
//  ex_br_taken   in   1      branch/jump resolved taken in EX
//  pc_en         out  1      PC write enable
//  ifid_en       out  1      IF/ID enable
//  ifid_flush    out  1      IF/ID synchronous clear
//  idex_en       out  1      ID/EX enable
//  idex_bubble   out  1      ID/EX synchronous clear (bubble)
//  exmem_bubble  out  1      EX/MEM synchronous clear (bubble)
//  mdu_busy      out  1      multi-cycle op in progress
//  mdu_done      out  1      one-cycle pulse in the last frozen cycle
//  perf_stalls   out  PERF_W count of cycles with pc_en=0
//  perf_flushes  out  PERF_W count of taken-branch flushes
// BEHAVIOUR
//  - Mealy: outputs are combinational from state, counter and current inputs.
//    State and counters are the only flops.
//  - rst high: outputs forced to pc_en=ifid_en=idex_en=1, all other outputs 0.
//    Next state is RUN, cnt=0, perf counters=0.
//  - Reset mid-MDU abandons the operation; no mdu_done is issued.
//  - States: RUN, MDU_BUSY.
//  - RUN, priority high to low:
//    1 ex_mdu_start: pc_en=ifid_en=idex_en=0, exmem_bubble=1, mdu_busy=1.
//      cnt <= LAT-1, with LAT = ex_mdu_div ? DIV_LAT : MUL_LAT.
//      If LAT>1: go to MDU_BUSY. If LAT==1: mdu_done=1, stay in RUN.
//    2 ex_br_taken: ifid_flush=1, idex_bubble=1, all enables 1.
//      A load-use match in the same cycle is ignored (wrong path).
//    3 load-use, when ex_mem_read && ex_rt!=0 && (ex_rt==id_rs ||
//      (id_uses_rt && ex_rt==id_rt)): pc_en=ifid_en=0, idex_bubble=1,
//      idex_en=1. Stall lasts exactly 1 cycle because the bubble clears
//      ex_mem_read.
//    4 otherwise: all enables 1, bubbles and flush 0.
//  - MDU_BUSY: pc_en=ifid_en=idex_en=0, exmem_bubble=1, mdu_busy=1.
//    cnt decrements each cycle. When cnt==1: mdu_done=1, next state RUN.
//    ex_br_taken, ex_mdu_start and the load-use compare are ignored.
//  - Total frozen cycles = LAT, counted from the ex_mdu_start cycle.
//    Enables return high in the cycle after mdu_done.
//  - ex_mdu_start together with ex_br_taken or ex_mem_read is illegal.
//    A simulation assertion flags it; the MDU path wins.
//  - $r0 never creates a hazard.
// CONFIGURATION
//  HAZ_PERF_EN defined:
//    perf_stalls increments in each non-reset cycle with pc_en==0.
//    perf_flushes increments in each cycle with ifid_flush==1.
//    Both wrap modulo 2^PERF_W and clear on rst.
//  HAZ_PERF_EN undefined: perf_stalls and perf_flushes are tied to 0 and no
//    counter flops are built. Ports are present in both builds.
// TESTING
//  1 Load at EX (ex_rt=5, ex_mem_read=1), id_rs=5 -> one cycle of
//    pc_en=0, ifid_en=0, idex_bubble=1; next cycle (ex_mem_read=0) all
//    enables 1.
//  2 ex_rt=0 with id_rs=0 and ex_mem_read=1 -> no stall.
//    Also id_rt match with id_uses_rt=0 -> no stall.
//  3 ex_mdu_start=1, ex_mdu_div=0 (MUL_LAT=4) -> pc_en=0 for exactly 4
//    cycles; mdu_done in cycle 4; pc_en=1 in cycle 5.
//    Repeat with ex_mdu_div=1 -> 32 frozen cycles.
//  4 ex_br_taken=1 in the same cycle as a load-use match -> ifid_flush=1,
//    idex_bubble=1, pc_en=1.
//    With HAZ_PERF_EN: perf_flushes +1 and perf_stalls unchanged.
//  5 rst asserted at frozen cycle 10 of a divide -> following cycle is RUN,
//    all enables 1, mdu_busy=0, no mdu_done, perf counters 0.
//  6 MUL_LAT=1 build: ex_mdu_start -> single frozen cycle with
//    mdu_busy=mdu_done=1; MDU_BUSY never entered.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall control for the PC, IF/ID, ID/EX and EX/MEM registers.
// Handles load-use stalls, taken-branch flushes and fixed-latency mult/div freezes.
// Outputs are Mealy: combinational from state, busy counter and current inputs.
// Optional build macro HAZ_PERF_EN adds the stall/flush performance counters;
// without it perf_stalls/perf_flushes are tied to zero.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rt,
  input  logic              ex_mem_read,
  input  logic              ex_mdu_start,
  input  logic              ex_mdu_div,
  input  logic              ex_br_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] perf_stalls,
  output logic [PERF_W-1:0] perf_flushes
);

  typedef enum logic [0:0] {StRun, StMduBusy} state_e;

  localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_LAT - 1);
  localparam logic             MulOne = (MUL_LAT == 1);
  localparam logic             DivOne = (DIV_LAT == 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             lat_one;

  // $r0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign lat_one  = ex_mdu_div ? DivOne : MulOne;

  // Next state, busy counter and all pipeline control strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mdu_busy     = 1'b0;
    mdu_done     = 1'b0;
    if (rst) begin
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_mdu_start) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            mdu_busy     = 1'b1;
            cnt_d        = ex_mdu_div ? DivCnt : MulCnt;
            if (lat_one) begin
              mdu_done = 1'b1;
            end else begin
              state_d = StMduBusy;
            end
          end else if (ex_br_taken) begin
            // Any load-use match this cycle is on the wrong path.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        StMduBusy: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          mdu_busy     = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            mdu_done = 1'b1;
            state_d  = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and busy counter; rst is folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] perf_stalls_q, perf_stalls_d;
  logic [PERF_W-1:0] perf_flushes_q, perf_flushes_d;

  // Free-running event counts, wrapping at 2^PERF_W.
  always_comb begin
    perf_stalls_d  = perf_stalls_q + PERF_W'(!pc_en);
    perf_flushes_d = perf_flushes_q + PERF_W'(ifid_flush);
    if (rst) begin
      perf_stalls_d  = '0;
      perf_flushes_d = '0;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    perf_stalls_q  <= perf_stalls_d;
    perf_flushes_q <= perf_flushes_d;
  end

  assign perf_stalls  = rst ? '0 : perf_stalls_q;
  assign perf_flushes = rst ? '0 : perf_flushes_q;
`else
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

  // A mult/div cannot share EX with a load or a taken branch.
  illegal_mdu_combo_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == StRun) |-> !(ex_mdu_start && (ex_br_taken || ex_mem_read)));

endmodule
